// File: rtl/divmod_pkg.sv
// Shared types and constants for the sequential divide/modulo unit.
// The flag bit positions are common with the ALU so both produce identical banderas.
package divmod_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREP,
        ITER,
        FIX,
        DONE
    } divmod_state_t;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/divmod_seq.sv
// Multi-cycle signed/unsigned divide/modulo unit built on a radix-2 restoring iteration.
// It uses a start/busy/done handshake and gives explicit results for divide-by-zero and signed overflow.
module divmod_seq
    import divmod_pkg::*;
#(
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         signed_op,
    input  logic         sel_rem,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] c,
    output logic [3:0]   banderas,
    output logic         busy,
    output logic         done,
    output logic         div_zero
);

    localparam int CW = $clog2(n);

    divmod_state_t state_q, state_d;
    logic [n-1:0]  dvd_q, dvd_d;
    logic [n-1:0]  dvs_q, dvs_d;
    logic [n-1:0]  rem_q, rem_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sgn_q, sgn_d;
    logic          sel_q, sel_d;
    logic          negq_q, negq_d;
    logic          negr_q, negr_d;
    logic          ovf_q, ovf_d;
    logic [n-1:0]  c_q, c_d;
    logic [3:0]    flags_q, flags_d;
    logic          dz_q, dz_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic [n:0]    shifted_s;
    logic [n:0]    trial_s;
    logic [n-1:0]  fix_q_s;
    logic [n-1:0]  fix_r_s;
    logic [n-1:0]  res_s;
    logic [n-1:0]  zero_res_s;

    function automatic logic [3:0] mk_flags(input logic [n-1:0] r, input logic sg, input logic v);
        logic [3:0] f;
        f         = 4'b0000;
        f[FLAG_N] = r[n-1] & sg;
        f[FLAG_Z] = (r == {n{1'b0}});
        f[FLAG_C] = 1'b0;
        f[FLAG_V] = v;
        return f;
    endfunction

    // Next-state, datapath and output computation for the divide FSM.
    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sgn_d   = sgn_q;
        sel_d   = sel_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        ovf_d   = ovf_q;
        c_d     = c_q;
        flags_d = flags_q;
        dz_d    = dz_q;

        // The quotient accumulates in the low end of dvd_q as the dividend bits shift out.
        shifted_s  = {rem_q, dvd_q[n-1]};
        trial_s    = shifted_s - {1'b0, dvs_q};
        fix_q_s    = negq_q ? -dvd_q : dvd_q;
        fix_r_s    = negr_q ? -rem_q : rem_q;
        res_s      = sel_q ? fix_r_s : fix_q_s;
        zero_res_s = sel_rem ? a : {n{1'b1}};

        case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d = a;
                    dvs_d = b;
                    sgn_d = signed_op;
                    sel_d = sel_rem;
                    if (b == {n{1'b0}}) begin
                        c_d     = zero_res_s;
                        flags_d = mk_flags(zero_res_s, signed_op, 1'b0);
                        dz_d    = 1'b1;
                        state_d = DONE;
                    end else begin
                        state_d = PREP;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            PREP: begin
                dvd_d   = (sgn_q & dvd_q[n-1]) ? -dvd_q : dvd_q;
                dvs_d   = (sgn_q & dvs_q[n-1]) ? -dvs_q : dvs_q;
                negq_d  = sgn_q & (dvd_q[n-1] ^ dvs_q[n-1]);
                negr_d  = sgn_q & dvd_q[n-1];
                ovf_d   = sgn_q & (dvd_q == {1'b1, {(n-1){1'b0}}}) & (dvs_q == {n{1'b1}});
                rem_d   = {n{1'b0}};
                cnt_d   = CW'(n - 1);
                state_d = ITER;
            end
            ITER: begin
                if (!trial_s[n]) begin
                    rem_d = trial_s[n-1:0];
                    dvd_d = {dvd_q[n-2:0], 1'b1};
                end else begin
                    rem_d = shifted_s[n-1:0];
                    dvd_d = {dvd_q[n-2:0], 1'b0};
                end
                if (cnt_q == {CW{1'b0}}) begin
                    state_d = FIX;
                end else begin
                    cnt_d   = cnt_q - CW'(1);
                    state_d = ITER;
                end
            end
            FIX: begin
                c_d     = res_s;
                flags_d = mk_flags(res_s, sgn_q, ovf_q);
                dz_d    = 1'b0;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    // State, datapath and registered output flops with asynchronous abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= {n{1'b0}};
            dvs_q   <= {n{1'b0}};
            rem_q   <= {n{1'b0}};
            cnt_q   <= {CW{1'b0}};
            sgn_q   <= 1'b0;
            sel_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            c_q     <= {n{1'b0}};
            flags_q <= 4'b0000;
            dz_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            sel_q   <= sel_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            ovf_q   <= ovf_d;
            c_q     <= c_d;
            flags_q <= flags_d;
            dz_q    <= dz_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign c        = c_q;
    assign banderas = flags_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;

endmodule
